// File: rtl/hazard_controller.sv
// Pipeline hazard controller: arbitrates memory freeze, EX redirects, load-use and
// fetch-not-ready each cycle; drives PC/pipeline-register controls, watchdog and counters.
module hazard_controller #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             ex_jal,
   input  logic             ex_jalr,
   input  logic [31:0]      ex_branch_target,
   input  logic [31:0]      ex_jal_target,
   input  logic [31:0]      ex_jalr_target,
   input  logic             dmem_busy,
   input  logic             imem_ready,
   output logic             pc_write,
   output logic             redirect_valid,
   output logic [31:0]      redirect_target,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic [1:0]       state,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_count
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] FREEZE   = 2'd1;
   localparam logic [1:0] LOAD_USE = 2'd2;
   localparam logic [1:0] FLUSH    = 2'd3;

   localparam logic [TO_W-1:0]  WD_MAX  = TO_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]      saved_state;
   logic [1:0]      eff_state;
   logic [1:0]      next_state;
   logic [TO_W-1:0] watchdog;
   logic [TO_W-1:0] watchdog_inc;
   logic            sup_ex;
   logic            sup_lu;
   logic            redir;
   logic            rs_match;
   logic            lu;

   // While frozen, suppression comes from the state that was interrupted.
   assign eff_state = (state == FREEZE) ? saved_state : state;
   assign sup_ex    = (eff_state == FLUSH);
   assign sup_lu    = (eff_state == LOAD_USE);

   assign redir    = !sup_ex && (ex_jalr || ex_jal || ex_branch_taken);
   assign rs_match = (id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd));
   assign lu       = !sup_lu && ex_mem_read && (ex_rd != 5'd0) && rs_match;

   assign watchdog_inc = watchdog + TO_W'(1);

   always_comb begin
      pc_write        = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'd0;
      if_id_stall     = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_stall     = 1'b0;
      id_ex_flush     = 1'b0;
      ex_mem_stall    = 1'b0;
      next_state      = RUN;
      if (!reset) begin
         next_state = RUN;
      end else if (dmem_busy) begin
         pc_write     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         next_state   = FREEZE;
      end else if (redir) begin
         redirect_valid  = 1'b1;
         redirect_target = ex_jalr ? ex_jalr_target :
                           ex_jal  ? ex_jal_target  : ex_branch_target;
         if_id_flush     = 1'b1;
         id_ex_flush     = 1'b1;
         next_state      = FLUSH;
      end else if (lu) begin
         pc_write    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
         next_state  = LOAD_USE;
      end else if (!imem_ready) begin
         pc_write    = 1'b1;
         if_id_flush = 1'b1;
         next_state  = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= RUN;
         saved_state    <= RUN;
         watchdog       <= '0;
         mem_timeout    <= 1'b0;
         stall_cycles   <= '0;
         redirect_count <= '0;
      end else begin
         state <= next_state;
         if (dmem_busy && (state != FREEZE))
            saved_state <= state;

         // Watchdog saturates at the limit; the flag is sticky until reset.
         if (dmem_busy) begin
            if (watchdog != WD_MAX) begin
               watchdog <= watchdog_inc;
               if (watchdog_inc == WD_MAX)
                  mem_timeout <= 1'b1;
            end else begin
               mem_timeout <= 1'b1;
            end
         end else begin
            watchdog <= '0;
         end

         if (pc_write && (stall_cycles != CNT_MAX))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (redirect_valid && (redirect_count != CNT_MAX))
            redirect_count <= redirect_count + CNT_W'(1);
      end
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Sequences the five-stage pipeline around the program counter and pipeline registers.
- Arbitrates between competing requests each cycle:
  - data-memory wait (freeze),
  - EX-stage control-flow redirects (branch/jal/jalr),
  - load-use hazards,
  - instruction-fetch not-ready.
- Drives PC hold/redirect and per-stage stall/flush controls, tracks post-event suppression state, and keeps a memory-wait watchdog plus performance counters.

Parameters:
- CNT_W, 32, width of the saturating performance counters.
- MEM_TIMEOUT, 255, consecutive dmem_busy cycles after which mem_timeout sets.
- TO_W, 8, width of the watchdog counter; must satisfy MEM_TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  ID-stage source registers.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1/rs2.
- ex_mem_read  in  1  EX-stage instruction is a load.
- ex_rd  in  5  EX-stage destination register.
- ex_branch_taken, ex_jal, ex_jalr  in  1 each  EX redirect requests.
- ex_branch_target, ex_jal_target, ex_jalr_target  in  32 each  redirect targets.
- dmem_busy  in  1  data memory not ready; whole pipeline must freeze.
- imem_ready  in  1  instruction fetch returned valid data this cycle.
- pc_write  out  1  1 = hold PC (program counter holds when high).
- redirect_valid  out  1  wired to PC branch_taken; PC jal/jalr inputs tied 0.
- redirect_target  out  32  wired to PC branch_target.
- if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall  out  1 each  pipeline-register controls.
- state  out  2  FSM state: RUN=0, FREEZE=1, LOAD_USE=2, FLUSH=3.
- mem_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  count of cycles with pc_write=1.
- redirect_count  out  CNT_W  count of redirect_valid pulses.

Behaviour:
- Reset (reset=0 at edge):
  - state=RUN, saved_state=RUN, watchdog=0, mem_timeout=0, both counters=0.
  - While reset is low, all control outputs are forced to 0.
- Control outputs are combinational from inputs and registered state, so they act in the same cycle (0 latency).
- Suppression flags are derived from the effective state: state, or saved_state while in FREEZE.
  - sup_ex = effective state is FLUSH; EX holds a flushed bubble, so ex_* inputs are ignored.
  - sup_lu = effective state is LOAD_USE; EX holds the inserted bubble, so the load-use check is skipped.
- Signals:
  - redir = !sup_ex & (ex_jalr | ex_jal | ex_branch_taken).
  - lu = !sup_lu & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Per-cycle priority; exactly one row applies, and unlisted outputs are 0:
  - P1, dmem_busy:
    - pc_write, if_id_stall, id_ex_stall, ex_mem_stall = 1; no flush, no redirect.
    - Next state FREEZE.
    - On entry from a non-FREEZE state, saved_state <= state; saved_state is held while in FREEZE.
  - P2, redir:
    - redirect_valid=1; redirect_target chosen with priority jalr > jal > branch.
    - if_id_flush=1, id_ex_flush=1, pc_write=0.
    - Next state FLUSH.
  - P3, lu:
    - pc_write=1, if_id_stall=1, id_ex_flush=1.
    - Next state LOAD_USE.
  - P4, !imem_ready:
    - pc_write=1, if_id_flush=1.
    - Next state RUN.
  - P5, otherwise: next state RUN.
- FREEZE exit: the first cycle with dmem_busy=0 uses saved_state for the suppression flags, then transitions normally.
- Simultaneous-event rules:
  - Redirect beats load-use, because the ID instruction is on the wrong path.
  - Redirect with imem_ready=0 still redirects.
  - A second redirect in the cycle after a redirect is ignored.
- Watchdog:
  - Increments each dmem_busy cycle; clears on any dmem_busy=0 cycle.
  - When it reaches MEM_TIMEOUT, mem_timeout sets and stays set until reset. The counter stops incrementing at MEM_TIMEOUT.
  - The freeze continues regardless of the watchdog.
- Counters:
  - Both saturate at 2**CNT_W-1 and never wrap.
  - stall_cycles counts P1, P3 and P4 cycles.
- Reset mid-freeze or mid-flush: returns to RUN with suppression cleared on the next cycle.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, all other requests idle → pc_write=1, if_id_stall=1, id_ex_flush=1, state→2. The next cycle with the same inputs gives no stall (sup_lu); stall_cycles=1.
- Redirect priority: ex_jal=1, ex_branch_taken=1, jal_target=0x100, branch_target=0x200 → redirect_target=0x100, both flushes=1, state→3.
  - Next cycle ex_jalr=1 → ignored, redirect_valid=0; redirect_count=1.
- Conflict: redirect plus load-use match in the same cycle → redirect_valid=1, pc_write=0, if_id_stall=0.
- Freeze across flush: redirect, then dmem_busy=1 for 3 cycles, with ex_branch_taken held 1 throughout → all four stalls=1 for 3 cycles, no redirect. The exit cycle still suppresses the redirect (saved FLUSH); stall_cycles=3.
- Watchdog: MEM_TIMEOUT=4, dmem_busy high 4 cycles → mem_timeout=1 after the 4th edge. Dropping dmem_busy keeps mem_timeout=1; reset=0 for one edge clears it.
- imem_ready=0 with no hazard → pc_write=1, if_id_flush=1, state stays 0. Counter saturation is checked with CNT_W=4: after 20 stall cycles stall_cycles=15.
